// File: rtl/blob_target_tracker.sv
// blob_target_tracker
//
// Picks one target blob out of each per-frame connected-components result
// set, smooths its position with a shift-based exponential moving average and
// drops the lock after a run of frames with no usable blob.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   blobs_valid_in   one-cycle pulse; result arrays valid in that cycle
//   num_blobs_in     number of populated label slots (clamped to MAX_LABELS)
//   area_in          per-slot area
//   com_x_in         per-slot centre-of-mass x
//   com_y_in         per-slot centre-of-mass y
//   target_x_out     smoothed target x
//   target_y_out     smoothed target y
//   target_area_out  area of the last selected blob
//   target_valid_out high while a target is locked
//   update_out       one-cycle pulse when a frame has been processed
//   lost_out         one-cycle pulse with update_out when the lock is dropped
//   busy_out         high from capture until update_out
//   dropped_out      one-cycle pulse when a frame arrives while busy
//
// state  | meaning
// IDLE   | waiting for blobs_valid_in; captures the result arrays
// SCAN   | examines one label slot per cycle, tracking the largest candidate
// FILTER | applies acquire / EMA / miss-count update to the target
// OUTPUT | update_out (and lost_out) visible for one cycle

module blob_target_tracker #(
    parameter int MAX_LABELS  = 5,
    parameter int AREA_W      = 17,
    parameter int MIN_AREA    = 20,
    parameter int LOST_FRAMES = 8,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               blobs_valid_in,
    input  logic [31:0]                        num_blobs_in,
    input  logic [MAX_LABELS-1:0][AREA_W-1:0]  area_in,
    input  logic [MAX_LABELS-1:0][10:0]        com_x_in,
    input  logic [MAX_LABELS-1:0][10:0]        com_y_in,
    output logic [10:0]                        target_x_out,
    output logic [10:0]                        target_y_out,
    output logic [AREA_W-1:0]                  target_area_out,
    output logic                               target_valid_out,
    output logic                               update_out,
    output logic                               lost_out,
    output logic                               busy_out,
    output logic                               dropped_out
);

    localparam int CNT_W  = $clog2(MAX_LABELS + 1);
    localparam int SLOT_W = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FILTER,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [MAX_LABELS-1:0][AREA_W-1:0] r_area;
    logic [MAX_LABELS-1:0][10:0]       r_com_x;
    logic [MAX_LABELS-1:0][10:0]       r_com_y;
    logic [CNT_W-1:0]                  r_n_eff;
    logic [CNT_W-1:0]                  r_idx;
    logic                              r_best_valid;
    logic [AREA_W-1:0]                 r_best_area;
    logic [10:0]                       r_best_x;
    logic [10:0]                       r_best_y;
    logic [7:0]                        r_miss;
    logic [10:0]                       r_tx;
    logic [10:0]                       r_ty;
    logic [AREA_W-1:0]                 r_tarea;
    logic                              r_tvalid;
    logic                              r_update;
    logic                              r_lost;
    logic                              r_busy;
    logic                              r_dropped;

    logic [CNT_W-1:0]  w_n_eff;
    logic [SLOT_W-1:0] w_slot;
    logic              w_cand;
    logic              w_better;
    logic              w_scan_last;
    logic [7:0]        w_miss_inc;
    logic              w_lose;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic [10:0]       w_ema_x;
    logic [10:0]       w_ema_y;

    assign w_n_eff = (num_blobs_in > 32'(MAX_LABELS)) ? CNT_W'(MAX_LABELS)
                                                      : num_blobs_in[CNT_W-1:0];

    assign w_slot      = r_idx[SLOT_W-1:0];
    assign w_cand      = (r_idx < r_n_eff) && (r_area[w_slot] >= AREA_W'(MIN_AREA));
    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_better    = w_cand && (!r_best_valid || (r_area[w_slot] > r_best_area));
    assign w_scan_last = (r_idx == CNT_W'(MAX_LABELS - 1));

    assign w_miss_inc = (r_miss >= 8'(LOST_FRAMES)) ? r_miss : r_miss + 8'd1;
    assign w_lose     = (w_miss_inc == 8'(LOST_FRAMES)) && r_tvalid;

    // Differences are taken 12-bit signed; the arithmetic shift floors toward
    // -inf, so the new value stays between current and candidate and fits 11 bits.
    assign w_dx    = $signed({1'b0, r_best_x}) - $signed({1'b0, r_tx});
    assign w_dy    = $signed({1'b0, r_best_y}) - $signed({1'b0, r_ty});
    assign w_ema_x = 11'($signed({1'b0, r_tx}) + (w_dx >>> ALPHA_SHIFT));
    assign w_ema_y = 11'($signed({1'b0, r_ty}) + (w_dy >>> ALPHA_SHIFT));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (blobs_valid_in) w_next_state = S_SCAN;
            S_SCAN:   if (w_scan_last)    w_next_state = S_FILTER;
            S_FILTER: w_next_state = S_OUTPUT;
            S_OUTPUT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_area       <= '0;
            r_com_x      <= '0;
            r_com_y      <= '0;
            r_n_eff      <= '0;
            r_idx        <= '0;
            r_best_valid <= 1'b0;
            r_best_area  <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_miss       <= '0;
            r_tx         <= '0;
            r_ty         <= '0;
            r_tarea      <= '0;
            r_tvalid     <= 1'b0;
            r_update     <= 1'b0;
            r_lost       <= 1'b0;
            r_busy       <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            // Anything arriving outside IDLE (OUTPUT included) is discarded.
            r_dropped <= blobs_valid_in && (r_state != S_IDLE);
            r_update  <= (r_state == S_FILTER);
            r_lost    <= (r_state == S_FILTER) && !r_best_valid && w_lose;

            case (r_state)
                S_IDLE: begin
                    if (blobs_valid_in) begin
                        r_area       <= area_in;
                        r_com_x      <= com_x_in;
                        r_com_y      <= com_y_in;
                        r_n_eff      <= w_n_eff;
                        r_idx        <= '0;
                        r_best_valid <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_better) begin
                        r_best_valid <= 1'b1;
                        r_best_area  <= r_area[w_slot];
                        r_best_x     <= r_com_x[w_slot];
                        r_best_y     <= r_com_y[w_slot];
                    end
                    r_idx <= r_idx + CNT_W'(1);
                end
                S_FILTER: begin
                    r_busy <= 1'b0;
                    if (r_best_valid) begin
                        if (!r_tvalid) begin
                            r_tx     <= r_best_x;
                            r_ty     <= r_best_y;
                            r_tvalid <= 1'b1;
                        end else begin
                            r_tx <= w_ema_x;
                            r_ty <= w_ema_y;
                        end
                        r_tarea <= r_best_area;
                        r_miss  <= '0;
                    end else begin
                        r_miss <= w_miss_inc;
                        if (w_lose) begin
                            r_tvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign target_x_out     = r_tx;
    assign target_y_out     = r_ty;
    assign target_area_out  = r_tarea;
    assign target_valid_out = r_tvalid;
    assign update_out       = r_update;
    assign lost_out         = r_lost;
    assign busy_out         = r_busy;
    assign dropped_out      = r_dropped;

endmodule

// File: tb/tb_blob_target_tracker.sv
// Bench for blob_target_tracker: a directed vector table covering acquire,
// EMA, tie/clamp, loss and re-acquire, hand sequences for overlap and reset,
// then random frames compared against a frame-level reference model.

module tb_blob_target_tracker;

    localparam int ML = 5;
    localparam int AW = 17;

    logic                      clk_in = 1'b0;
    logic                      rst_n_in = 1'b0;
    logic                      blobs_valid_in;
    logic [31:0]               num_blobs_in;
    logic [ML-1:0][AW-1:0]     area_in;
    logic [ML-1:0][10:0]       com_x_in;
    logic [ML-1:0][10:0]       com_y_in;
    logic [10:0]               target_x_out;
    logic [10:0]               target_y_out;
    logic [AW-1:0]             target_area_out;
    logic                      target_valid_out;
    logic                      update_out;
    logic                      lost_out;
    logic                      busy_out;
    logic                      dropped_out;

    always #5 clk_in = ~clk_in;

    blob_target_tracker #(
        .MAX_LABELS (ML),
        .AREA_W     (AW),
        .MIN_AREA   (20),
        .LOST_FRAMES(8),
        .ALPHA_SHIFT(2)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .blobs_valid_in  (blobs_valid_in),
        .num_blobs_in    (num_blobs_in),
        .area_in         (area_in),
        .com_x_in        (com_x_in),
        .com_y_in        (com_y_in),
        .target_x_out    (target_x_out),
        .target_y_out    (target_y_out),
        .target_area_out (target_area_out),
        .target_valid_out(target_valid_out),
        .update_out      (update_out),
        .lost_out        (lost_out),
        .busy_out        (busy_out),
        .dropped_out     (dropped_out)
    );

    typedef struct packed {
        logic [31:0]           n;
        logic [ML-1:0][AW-1:0] area;
        logic [ML-1:0][10:0]   x;
        logic [ML-1:0][10:0]   y;
        logic [10:0]           ex;
        logic [10:0]           ey;
        logic [AW-1:0]         ea;
        logic                  ev;
        logic                  el;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_valid, m_x, m_y, m_area, m_miss, m_lost;

    // outputs captured in the update_out cycle
    logic [10:0]   s_x, s_y;
    logic [AW-1:0] s_area;
    logic          s_valid, s_lost;

    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n,
                                input int a0, input int a1, input int a2, input int a3, input int a4,
                                input int x0, input int x1, input int x2, input int x3, input int x4,
                                input int y0, input int y1, input int y2, input int y3, input int y4,
                                input int ex, input int ey, input int ea, input int ev, input int el);
        vec_t v;
        v = '0;
        v.n = 32'(n);
        v.area[0] = AW'(a0); v.area[1] = AW'(a1); v.area[2] = AW'(a2);
        v.area[3] = AW'(a3); v.area[4] = AW'(a4);
        v.x[0] = 11'(x0); v.x[1] = 11'(x1); v.x[2] = 11'(x2); v.x[3] = 11'(x3); v.x[4] = 11'(x4);
        v.y[0] = 11'(y0); v.y[1] = 11'(y1); v.y[2] = 11'(y2); v.y[3] = 11'(y3); v.y[4] = 11'(y4);
        v.ex = 11'(ex);
        v.ey = 11'(ey);
        v.ea = AW'(ea);
        v.ev = (ev != 0);
        v.el = (el != 0);
        return v;
    endfunction

    // floor(d / 4) computed with plain integer division
    function automatic int floor_div4(input int d);
        if (d >= 0) return d / 4;
        return -((-d + 3) / 4);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_x = 0; m_y = 0; m_area = 0; m_miss = 0; m_lost = 0;
    endtask

    task automatic model_frame(input vec_t v);
        int n_eff;
        int best;
        n_eff = (v.n > 32'd5) ? 5 : int'(v.n);
        best = -1;
        for (int i = 0; i < n_eff; i++) begin
            if (int'(v.area[i]) >= 20) begin
                if (best < 0 || int'(v.area[i]) > int'(v.area[best])) best = i;
            end
        end
        m_lost = 0;
        if (best >= 0) begin
            if (m_valid == 0) begin
                m_x = int'(v.x[best]);
                m_y = int'(v.y[best]);
                m_valid = 1;
            end else begin
                m_x = m_x + floor_div4(int'(v.x[best]) - m_x);
                m_y = m_y + floor_div4(int'(v.y[best]) - m_y);
            end
            m_area = int'(v.area[best]);
            m_miss = 0;
        end else begin
            if (m_miss < 8) m_miss++;
            if (m_miss == 8 && m_valid != 0) begin
                m_valid = 0;
                m_lost = 1;
            end
        end
    endtask

    // Sends one frame and watches 9 cycles after capture. pulse_at (1..7)
    // re-asserts blobs_valid_in for one cycle during processing.
    task automatic run_frame(input vec_t v, input int pulse_at);
        int got;
        int extra;
        int stray;
        logic busy_ok;
        got = -1; extra = 0; stray = 0; busy_ok = 1'b1;
        @(negedge clk_in);
        num_blobs_in   = v.n;
        area_in        = v.area;
        com_x_in       = v.x;
        com_y_in       = v.y;
        blobs_valid_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_in);
            blobs_valid_in = (k == pulse_at);
            if (k <= 6 && busy_out !== 1'b1) busy_ok = 1'b0;
            if (k >= 7 && busy_out !== 1'b0) busy_ok = 1'b0;
            if (update_out === 1'b1) begin
                if (got < 0) begin
                    got = k;
                    s_x = target_x_out; s_y = target_y_out; s_area = target_area_out;
                    s_valid = target_valid_out; s_lost = lost_out;
                end else begin
                    extra++;
                end
            end
            if (pulse_at != 0 && k == pulse_at + 1) check("dropped_pulse", 64'(dropped_out), 64'd1);
            else if (dropped_out !== 1'b0) stray++;
        end
        check("update_latency", 64'(got), 64'd7);
        check("busy_window", 64'(busy_ok), 64'd1);
        check("single_update", 64'(extra), 64'd0);
        check("no_stray_drop", 64'(stray), 64'd0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"},     64'(s_x),     64'(m_x));
        check({tag, "_y"},     64'(s_y),     64'(m_y));
        check({tag, "_area"},  64'(s_area),  64'(m_area));
        check({tag, "_valid"}, 64'(s_valid), 64'(m_valid));
        check({tag, "_lost"},  64'(s_lost),  64'(m_lost));
    endtask

    task automatic check_all_zero(input string name);
        check(name, {target_x_out, target_y_out, target_area_out, target_valid_out,
                     update_out, lost_out, busy_out, dropped_out}, 64'd0);
    endtask

    function automatic vec_t rnd_vec(input int force_low);
        vec_t v;
        int r;
        v = '0;
        r = int'($urandom_range(0, 9));
        if (r == 0)      v.n = 32'd0;
        else if (r == 1) v.n = $urandom_range(6, 100000);
        else             v.n = $urandom_range(1, 5);
        for (int i = 0; i < ML; i++) begin
            if (force_low != 0) v.area[i] = AW'($urandom_range(0, 19));
            else                v.area[i] = AW'($urandom_range(0, 60));
            v.x[i] = 11'($urandom_range(0, 2047));
            v.y[i] = 11'($urandom_range(0, 2047));
        end
        return v;
    endfunction

    initial begin
        vec_t v;
        int upd;

        blobs_valid_in = 1'b0;
        num_blobs_in   = '0;
        area_in        = '0;
        com_x_in       = '0;
        com_y_in       = '0;
        model_reset();

        repeat (2) @(negedge clk_in);
        check_all_zero("reset_outputs");
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("post_reset_busy", 64'(busy_out), 64'd0);
        check("post_reset_valid", 64'(target_valid_out), 64'd0);

        // directed table
        tbl[0] = mk(3, 10,50,30,0,0, 5,100,200,0,0, 7,60,90,0,0, 100,60,50,1,0);
        tbl[1] = mk(1, 40,0,0,0,0, 140,0,0,0,0, 60,0,0,0,0, 110,60,40,1,0);
        tbl[2] = mk(1, 40,0,0,0,0, 99,0,0,0,0, 60,0,0,0,0, 107,60,40,1,0);
        tbl[3] = mk(2, 40,40,0,1000,0, 10,20,0,500,0, 60,60,0,0,0, 82,60,40,1,0);
        for (int i = 4; i <= 10; i++)
            tbl[i] = mk(5, 19,5,0,19,1, 1,2,3,4,5, 6,7,8,9,10, 82,60,40,1,0);
        tbl[11] = mk(5, 19,5,0,19,1, 1,2,3,4,5, 6,7,8,9,10, 82,60,40,0,1);
        tbl[12] = mk(5, 19,5,0,19,1, 1,2,3,4,5, 6,7,8,9,10, 82,60,40,0,0);
        tbl[13] = mk(1, 25,0,0,0,0, 300,0,0,0,0, 150,0,0,0,0, 300,150,25,1,0);
        tbl[14] = mk(0, 100,100,100,100,100, 9,9,9,9,9, 9,9,9,9,9, 300,150,25,1,0);
        tbl[15] = mk(100, 30,0,0,0,0, 310,0,0,0,0, 150,0,0,0,0, 302,150,30,1,0);
        tbl[16] = mk(1, 20,0,0,0,0, 302,0,0,0,0, 0,0,0,0,0, 302,112,20,1,0);

        for (int i = 0; i < 17; i++) begin
            run_frame(tbl[i], 0);
            model_frame(tbl[i]);
            check($sformatf("tbl%0d_x", i),     64'(s_x),     64'(tbl[i].ex));
            check($sformatf("tbl%0d_y", i),     64'(s_y),     64'(tbl[i].ey));
            check($sformatf("tbl%0d_area", i),  64'(s_area),  64'(tbl[i].ea));
            check($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_lost", i),  64'(s_lost),  64'(tbl[i].el));
        end

        // overlap: a second pulse mid-scan and one in the OUTPUT cycle
        v = mk(2, 45,30,0,0,0, 700,5,0,0,0, 400,5,0,0,0, 0,0,0,0,0);
        run_frame(v, 3);
        model_frame(v);
        check_model("overlap_scan");
        v = mk(1, 33,0,0,0,0, 2047,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        run_frame(v, 7);
        model_frame(v);
        check_model("overlap_output");

        // random frames; frames 20..31 are forced misses to drive a loss
        for (int f = 0; f < 60; f++) begin
            v = rnd_vec((f >= 20 && f < 32) ? 1 : 0);
            run_frame(v, (f % 7 == 3) ? int'($urandom_range(1, 7)) : 0);
            model_frame(v);
            check_model($sformatf("rnd%0d", f));
        end

        // mid-clock reset while locked
        v = mk(1, 50,0,0,0,0, 123,0,0,0,0, 456,0,0,0,0, 0,0,0,0,0);
        run_frame(v, 0);
        model_frame(v);
        check_model("pre_reset");
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("midclock_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();

        // reset during SCAN: no update may follow
        v = mk(1, 50,0,0,0,0, 11,0,0,0,0, 22,0,0,0,0, 0,0,0,0,0);
        @(negedge clk_in);
        num_blobs_in = v.n; area_in = v.area; com_x_in = v.x; com_y_in = v.y;
        blobs_valid_in = 1'b1;
        @(negedge clk_in);
        blobs_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check_all_zero("scan_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        upd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (update_out === 1'b1 || busy_out === 1'b1) upd++;
        end
        check("no_update_after_reset", 64'(upd), 64'd0);

        // after reset the next frame acquires directly
        v = mk(4, 0,21,0,22,0, 0,9,0,1500,0, 0,9,0,777,0, 0,0,0,0,0);
        run_frame(v, 0);
        model_frame(v);
        check_model("reacquire_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
